fpdiv_seq_ctrl: RTL



---
 rtl/fpdiv_pkg.sv | 23 ++
 rtl/fpdiv_mant_step.sv | 17 +
 rtl/fpdiv_seq_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/fpdiv_pkg.sv
// Shared types and constants for the sequential single-precision divider.
package fpdiv_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_DIV,
        S_NORM,
        S_DONE
    } state_t;

    localparam int BIAS  = 127;
    localparam int QBITS = 27;
    localparam int EXP_W = 10;
    localparam logic [31:0] QNAN = 32'h7FC00000;

    // Bit positions inside flags = {invalid, div_by_zero, overflow, underflow}
    localparam int FLAG_INVALID = 3;
    localparam int FLAG_DIV0    = 2;
    localparam int FLAG_OVF     = 1;
    localparam int FLAG_UNF     = 0;

endpackage

// File: rtl/fpdiv_mant_step.sv
// One restoring-division step: subtract the divisor when it fits, then shift.
module fpdiv_mant_step (
    input  logic [24:0] r,
    input  logic [23:0] b_m,
    output logic [24:0] r_next,
    output logic        qbit
);

    logic [24:0] sel;

    always_comb begin
        qbit   = (r >= {1'b0, b_m});
        sel    = qbit ? (r - {1'b0, b_m}) : r;
        r_next = sel << 1;
    end

endmodule

// File: rtl/fpdiv_seq_ctrl.sv
// Sequential IEEE-754 single divider controller (flush-to-zero, iterative restoring).
// Define FPDIV_ROUND_NEAREST_EN for round-to-nearest-even; default build truncates.
module fpdiv_seq_ctrl
    import fpdiv_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] q,
    output logic [3:0]  flags,
    output logic        busy
);

    localparam logic [4:0] CNT_LAST = 5'(QBITS / BITS_PER_CYCLE - 1);
    localparam logic signed [EXP_W-1:0] EXP_MAX = 10'sd255;
    localparam logic signed [EXP_W-1:0] EXP_MIN = 10'sd0;

    state_t state, state_nxt;
    logic [4:0]  cnt;
    logic [31:0] a_reg, b_reg;
    logic [24:0] rem;
    logic [23:0] b_m;
    logic [QBITS-1:0] quo, quo_nxt;
    logic signed [EXP_W-1:0] exp_r, norm_e;
    logic        sign;

    logic        a_nan, a_inf, a_zero, b_nan, b_inf, b_zero, sgn;
    logic        spec_hit;
    logic [31:0] spec_q, norm_q;
    logic [3:0]  spec_flags, norm_flags;

`ifdef FPDIV_ROUND_NEAREST_EN
    function automatic logic [24:0] round_rne(input logic [23:0] m, input logic g, input logic s);
        return {1'b0, m} + {24'd0, g & (s | m[0])};
    endfunction

    logic [23:0] mant;
    logic [24:0] rnd;
    logic        guard, sticky;
`endif

    assign in_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);

    // Operand classification; exponent 0 means zero (denormals flushed)
    assign a_nan  = (&a_reg[30:23]) &  (|a_reg[22:0]);
    assign a_inf  = (&a_reg[30:23]) & ~(|a_reg[22:0]);
    assign a_zero = (a_reg[30:23] == 8'd0);
    assign b_nan  = (&b_reg[30:23]) &  (|b_reg[22:0]);
    assign b_inf  = (&b_reg[30:23]) & ~(|b_reg[22:0]);
    assign b_zero = (b_reg[30:23] == 8'd0);
    assign sgn    = a_reg[31] ^ b_reg[31];

    always_comb begin
        spec_hit   = 1'b1;
        spec_q     = '0;
        spec_flags = '0;
        if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf)) begin
            spec_q                   = QNAN;
            spec_flags[FLAG_INVALID] = 1'b1;
        end else if (a_inf) begin
            spec_q = {sgn, 8'hFF, 23'd0};
        end else if (b_zero) begin
            spec_q                = {sgn, 8'hFF, 23'd0};
            spec_flags[FLAG_DIV0] = 1'b1;
        end else if (a_zero | b_inf) begin
            spec_q = {sgn, 31'd0};
        end else begin
            spec_hit = 1'b0;
        end
    end

    logic [BITS_PER_CYCLE:0][24:0]  rr;
    logic [BITS_PER_CYCLE-1:0]      step_bits;

    assign rr[0] = rem;
    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
        fpdiv_mant_step u_step (
            .r      (rr[i]),
            .b_m    (b_m),
            .r_next (rr[i+1]),
            .qbit   (step_bits[BITS_PER_CYCLE-1-i])
        );
    end
    assign quo_nxt = {quo[QBITS-1-BITS_PER_CYCLE:0], step_bits};

    // Normalise the quotient (value in [0.5, 2)) and pack
    always_comb begin
        norm_q     = '0;
        norm_flags = '0;
        norm_e     = quo[QBITS-1] ? exp_r : exp_r - 10'sd1;
`ifdef FPDIV_ROUND_NEAREST_EN
        mant   = quo[QBITS-1] ? quo[26:3] : quo[25:2];
        guard  = quo[QBITS-1] ? quo[2] : quo[1];
        sticky = (quo[QBITS-1] ? |quo[1:0] : quo[0]) | (rem != 25'd0);
        rnd    = round_rne(mant, guard, sticky);
        if (rnd[24]) begin
            norm_e = norm_e + 10'sd1;
            norm_q = {sign, 8'd0, rnd[23:1]};
        end else begin
            norm_q = {sign, 8'd0, rnd[22:0]};
        end
`else
        norm_q = {sign, 8'd0, (quo[QBITS-1] ? quo[25:3] : quo[24:2])};
`endif
        if (norm_e >= EXP_MAX) begin
            norm_q               = {sign, 8'hFF, 23'd0};
            norm_flags[FLAG_OVF] = 1'b1;
        end else if (norm_e <= EXP_MIN) begin
            norm_q               = {sign, 31'd0};
            norm_flags[FLAG_UNF] = 1'b1;
        end else begin
            norm_q[30:23] = norm_e[7:0];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (in_valid) state_nxt = S_UNPACK;
            S_UNPACK: state_nxt = spec_hit ? S_DONE : S_DIV;
            S_DIV:    if (cnt == 5'd0) state_nxt = S_NORM;
            S_NORM:   state_nxt = S_DONE;
            S_DONE:   if (out_valid && out_ready) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // out_valid rises on the cycle after DONE is entered and drops at the handshake
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            out_valid <= 1'b0;
            q         <= '0;
            flags     <= '0;
        end else begin
            case (state)
                S_UNPACK: begin
                    cnt <= CNT_LAST;
                    if (spec_hit) begin
                        q     <= spec_q;
                        flags <= spec_flags;
                    end
                end
                S_DIV:  if (cnt != 5'd0) cnt <= cnt - 5'd1;
                S_NORM: begin
                    q     <= norm_q;
                    flags <= norm_flags;
                end
                S_DONE: begin
                    if (!out_valid)     out_valid <= 1'b1;
                    else if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        case (state)
            S_IDLE: if (in_valid) begin
                a_reg <= a;
                b_reg <= b;
            end
            S_UNPACK: begin
                rem   <= {2'b01, a_reg[22:0]};
                b_m   <= {1'b1, b_reg[22:0]};
                sign  <= sgn;
                quo   <= '0;
                exp_r <= $signed({2'b00, a_reg[30:23]}) - $signed({2'b00, b_reg[30:23]})
                         + $signed(EXP_W'(BIAS));
            end
            S_DIV: begin
                rem <= rr[BITS_PER_CYCLE];
                quo <= quo_nxt;
            end
            default: ;
        endcase
    end

endmodule
